// File: rtl/shift_right_serial_if.sv
// Request/result bundle for the serial right shifter.
// The requester drives start/in/shamt/arith. The shifter returns out/busy/done.
interface shift_right_serial_if #(
  parameter int Width      = 32,
  parameter int ShamtWidth = 5
);
  logic                  start;
  logic [Width-1:0]      in;
  logic [ShamtWidth-1:0] shamt;
  logic                  arith;
  logic [Width-1:0]      out;
  logic                  busy;
  logic                  done;

  modport master (
    output start, in, shamt, arith,
    input  out, busy, done
  );

  modport slave (
    input  start, in, shamt, arith,
    output out, busy, done
  );
endinterface

// File: rtl/shift_right_serial.sv
// Serial SRL/SRA shifter that moves one bit per clock. Done fires shamt+1 cycles after accept.
// A start request is honoured only in IDLE or DONE; start during SHIFT is dropped, not queued.
module shift_right_serial #(
  parameter int Width      = 32,
  parameter int ShamtWidth = 5
) (
  input logic                clk,
  input logic                rst_n,
  shift_right_serial_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state;
  logic [Width-1:0]      data;
  logic [Width-1:0]      data_nxt;
  logic [ShamtWidth-1:0] cnt;
  logic                  fill;
  logic                  busy_q;
  logic                  done_q;
  logic                  shift_en;

  assign shift_en = (state == SHIFT) && (cnt != '0);

  // One 2:1 mux per bit: either keep the bit or take its left neighbour.
  genvar i;
  generate
    for (i = 0; i < Width - 1; i++) begin : g_mux
      assign data_nxt[i] = shift_en ? data[i+1] : data[i];
    end
  endgenerate
  assign data_nxt[Width-1] = shift_en ? fill : data[Width-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      data   <= '0;
      cnt    <= '0;
      fill   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            data   <= bus.in;
            cnt    <= bus.shamt;
            fill   <= bus.arith & bus.in[Width-1];
            state  <= SHIFT;
            busy_q <= 1'b1;
            done_q <= 1'b0;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            data <= data_nxt;
            cnt  <= cnt - ShamtWidth'(1);
          end else begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out  = data;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
